// File: rtl/gps_acq_scheduler.sv
// GPS C/A acquisition scheduler: walks enabled PRNs x Doppler bins x code
// phases over one captured snapshot, driving a shared correlator engine.
module gps_acq_scheduler #(
  parameter int                 NUM_SAT      = 32,
  parameter int                 CODE_PHASES  = 1023,
  parameter int                 DOPPLER_BINS = 21,
  parameter logic signed [15:0] DOPPLER_MIN  = -16'sd1310,
  parameter logic signed [15:0] DOPPLER_STEP = 16'sd131,
  parameter int                 CORR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_SAT-1:0] sat_mask,
  input  logic [CORR_W-1:0] threshold,
  output logic              busy,
  output logic              done,
  output logic              capture_req,
  input  logic              capture_ack,
  output logic              corr_start,
  output logic [5:0]        corr_sat,
  output logic [9:0]        corr_code_phase,
  output logic [15:0]       corr_doppler_omega,
  input  logic              corr_done,
  input  logic [CORR_W-1:0] corr_value,
  output logic              result_valid,
  output logic [5:0]        result_sat,
  output logic [9:0]        result_code_phase,
  output logic [4:0]        result_doppler_idx,
  output logic [CORR_W-1:0] result_peak,
  output logic              result_detect
);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_SEL_SAT, S_ISSUE,
    S_WAIT, S_UPDATE, S_REPORT, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [NUM_SAT-1:0] r_mask;
  logic [CORR_W-1:0]  r_thr;
  logic [5:0]         r_idx;
  logic [9:0]         r_phase;
  logic [4:0]         r_bin;
  logic signed [15:0] r_omega;
  logic [CORR_W-1:0]  r_val;
  logic [CORR_W-1:0]  r_peak;
  logic [9:0]         r_pk_phase;
  logic [4:0]         r_pk_bin;

  logic               r_corr_start;
  logic [5:0]         r_corr_sat;
  logic [9:0]         r_corr_phase;
  logic [15:0]        r_corr_omega;
  logic               r_res_valid;
  logic [5:0]         r_res_sat;
  logic [9:0]         r_res_phase;
  logic [4:0]         r_res_bin;
  logic [CORR_W-1:0]  r_res_peak;
  logic               r_res_det;

  logic [NUM_SAT:0]   w_mask_x;
  logic               w_sat_en;
  logic               w_idx_end;
  logic               w_last_phase;
  logic               w_last_bin;

  assign w_mask_x     = {1'b0, r_mask};
  assign w_sat_en     = w_mask_x[r_idx];
  assign w_idx_end    = (r_idx >= 6'(NUM_SAT));
  assign w_last_phase = (r_phase == 10'(CODE_PHASES - 1));
  assign w_last_bin   = (r_bin == 5'(DOPPLER_BINS - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = S_CAPTURE;
      S_CAPTURE: begin
        if (r_mask == '0)     w_next = S_DONE;
        else if (capture_ack) w_next = S_SEL_SAT;
      end
      S_SEL_SAT: begin
        if (w_idx_end)     w_next = S_DONE;
        else if (w_sat_en) w_next = S_ISSUE;
      end
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (corr_done) w_next = S_UPDATE;
      S_UPDATE:  w_next = (w_last_phase && w_last_bin) ? S_REPORT : S_ISSUE;
      S_REPORT:  w_next = S_SEL_SAT;
      S_DONE:    w_next = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE && r_state != S_DONE)
      w_next = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_thr        <= '0;
      r_idx        <= '0;
      r_phase      <= '0;
      r_bin        <= '0;
      r_omega      <= '0;
      r_val        <= '0;
      r_peak       <= '0;
      r_pk_phase   <= '0;
      r_pk_bin     <= '0;
      r_corr_start <= 1'b0;
      r_corr_sat   <= '0;
      r_corr_phase <= '0;
      r_corr_omega <= '0;
      r_res_valid  <= 1'b0;
      r_res_sat    <= '0;
      r_res_phase  <= '0;
      r_res_bin    <= '0;
      r_res_peak   <= '0;
      r_res_det    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_corr_start <= 1'b0;
      r_res_valid  <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_mask <= sat_mask;
          r_thr  <= threshold;
          r_idx  <= '0;
        end
        S_SEL_SAT: begin
          r_phase    <= '0;
          r_bin      <= '0;
          r_omega    <= DOPPLER_MIN;
          r_peak     <= '0;
          r_pk_phase <= '0;
          r_pk_bin   <= '0;
          if (!w_idx_end && !w_sat_en) r_idx <= r_idx + 6'd1;
        end
        S_ISSUE: if (!abort) begin
          r_corr_start <= 1'b1;
          r_corr_sat   <= r_idx + 6'd1;
          r_corr_phase <= r_phase;
          r_corr_omega <= r_omega;
        end
        S_WAIT: if (corr_done) r_val <= corr_value;
        S_UPDATE: begin
          // strict compare keeps the earliest point on ties
          if (r_val > r_peak) begin
            r_peak     <= r_val;
            r_pk_phase <= r_phase;
            r_pk_bin   <= r_bin;
          end
          if (w_last_phase) begin
            r_phase <= '0;
            r_bin   <= r_bin + 5'd1;
            r_omega <= r_omega + DOPPLER_STEP;
          end else begin
            r_phase <= r_phase + 10'd1;
          end
        end
        S_REPORT: begin
          if (!abort) begin
            r_res_valid <= 1'b1;
            r_res_sat   <= r_idx + 6'd1;
            r_res_phase <= r_pk_phase;
            r_res_bin   <= r_pk_bin;
            r_res_peak  <= r_peak;
            r_res_det   <= (r_peak >= r_thr);
          end
          r_idx <= r_idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy               = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done               = (r_state == S_DONE);
  assign capture_req        = (r_state == S_CAPTURE) && (r_mask != '0);
  assign corr_start         = r_corr_start;
  assign corr_sat           = r_corr_sat;
  assign corr_code_phase    = r_corr_phase;
  assign corr_doppler_omega = r_corr_omega;
  assign result_valid       = r_res_valid;
  assign result_sat         = r_res_sat;
  assign result_code_phase  = r_res_phase;
  assign result_doppler_idx = r_res_bin;
  assign result_peak        = r_res_peak;
  assign result_detect      = r_res_det;

endmodule
